// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-to-physical-memory arbiter.
package cache_arbiter_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned LINE_W = 128;

   typedef logic [WORD_W-1:0] lc3b_word;
   typedef logic [LINE_W-1:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } lc3b_arb_state;

   // 0 = instruction cache, 1 = data cache
   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } lc3b_arb_sel;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter state machine: picks a requester in IDLE, waits for memory completion.
module cache_arbiter_control
   import cache_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic        d_req,
   input  logic        pmem_resp,
   output logic        grant_load,
   output lc3b_arb_sel grant_sel,
   output logic        done,
   output logic        i_resp,
   output logic        d_resp
);

   lc3b_arb_state state;
   lc3b_arb_sel   last_grant;

   // Grant decision: on a tie, the requester not served last wins.
   always_comb begin
      grant_load = 1'b0;
      grant_sel  = SEL_I;
      if (state == IDLE) begin
         grant_load = i_req | d_req;
      end
      if (i_req && d_req) begin
         grant_sel = (last_grant == SEL_I) ? SEL_D : SEL_I;
      end else if (d_req) begin
         grant_sel = SEL_D;
      end
   end

   // Completion pulses pass straight through to the granted cache only.
   always_comb begin
      i_resp = (state == SERVE_I) & pmem_resp;
      d_resp = (state == SERVE_D) & pmem_resp;
      done   = i_resp | d_resp;
   end

   // State and fairness history; every completion returns to IDLE for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= SEL_D;
      end else begin
         case (state)
            IDLE: begin
               if (grant_load) begin
                  last_grant <= grant_sel;
                  state      <= (grant_sel == SEL_D) ? SERVE_D : SERVE_I;
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and the D-cache.
module cache_arbiter
   import cache_arbiter_pkg::*;
(
   input  logic     clk,
   input  logic     rst,

   input  logic     i_pmem_read,
   input  lc3b_word i_pmem_address,
   output lc3b_line i_pmem_rdata,
   output logic     i_pmem_resp,

   input  logic     d_pmem_read,
   input  logic     d_pmem_write,
   input  lc3b_word d_pmem_address,
   input  lc3b_line d_pmem_wdata,
   output lc3b_line d_pmem_rdata,
   output logic     d_pmem_resp,

   output logic     pmem_read,
   output logic     pmem_write,
   output lc3b_word pmem_address,
   output lc3b_line pmem_wdata,
   input  lc3b_line pmem_rdata,
   input  logic     pmem_resp
);

   logic        d_req;
   logic        grant_load;
   lc3b_arb_sel grant_sel;
   logic        done;
   lc3b_word    grant_address;

   assign d_req = d_pmem_read | d_pmem_write;

   cache_arbiter_control u_control (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_pmem_read),
      .d_req      (d_req),
      .pmem_resp  (pmem_resp),
      .grant_load (grant_load),
      .grant_sel  (grant_sel),
      .done       (done),
      .i_resp     (i_pmem_resp),
      .d_resp     (d_pmem_resp)
   );

   // Address of whichever requester is being granted this cycle.
   always_comb begin
      grant_address = (grant_sel == SEL_D) ? d_pmem_address : i_pmem_address;
   end

   // Memory-side latch: address, write line and op captured at grant, held to completion.
   // Read+write together from the D-cache is treated as a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else if (grant_load) begin
         pmem_address <= grant_address;
         if (grant_sel == SEL_D) begin
            pmem_wdata <= d_pmem_wdata;
            pmem_read  <= ~d_pmem_write;
            pmem_write <= d_pmem_write;
         end else begin
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
         end
      end else if (done) begin
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
      end
   end

   // Returned line is broadcast; only the resp pulses are steered.
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: reference model plus directed scenarios.
module tb_cache_arbiter;

   logic         clk;
   logic         rst;
   logic         i_pmem_read;
   logic [15:0]  i_pmem_address;
   logic [127:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic         d_pmem_read;
   logic         d_pmem_write;
   logic [15:0]  d_pmem_address;
   logic [127:0] d_pmem_wdata;
   logic [127:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   int checks;
   int failures;

   cache_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner: 0 = memory port free, 1 = I-cache transaction open, 2 = D-cache transaction open
   int           m_owner;
   bit           m_last_d;
   bit           m_valid;
   bit           m_wr;
   logic [15:0]  m_addr;
   logic [127:0] m_wdata;

   initial m_valid = 1'b0;

   function automatic bit pick_d(input bit iq, input bit dq, input bit last_d);
      return (iq && dq) ? !last_d : dq;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_owner  <= 0;
         m_last_d <= 1'b1;
         m_wr     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_valid  <= 1'b1;
      end else if (m_valid) begin
         if (m_owner == 0) begin
            if (i_pmem_read || d_pmem_read || d_pmem_write) begin
               if (pick_d(i_pmem_read, d_pmem_read || d_pmem_write, m_last_d)) begin
                  m_owner  <= 2;
                  m_last_d <= 1'b1;
                  m_addr   <= d_pmem_address;
                  m_wdata  <= d_pmem_wdata;
                  m_wr     <= d_pmem_write;
               end else begin
                  m_owner  <= 1;
                  m_last_d <= 1'b0;
                  m_addr   <= i_pmem_address;
               end
            end
         end else if (pmem_resp) begin
            m_owner <= 0;
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_pmem_read",  128'(pmem_read),  128'((m_owner == 1) || (m_owner == 2 && !m_wr)));
         chk("cyc_pmem_write", 128'(pmem_write), 128'(m_owner == 2 && m_wr));
         chk("cyc_pmem_address", 128'(pmem_address), 128'(m_addr));
         chk("cyc_pmem_wdata", pmem_wdata, m_wdata);
         chk("cyc_i_resp", 128'(i_pmem_resp), 128'(m_owner == 1 && pmem_resp));
         chk("cyc_d_resp", 128'(d_pmem_resp), 128'(m_owner == 2 && pmem_resp));
         chk("cyc_i_rdata", i_pmem_rdata, pmem_rdata);
         chk("cyc_d_rdata", d_pmem_rdata, pmem_rdata);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory answers lat cycles after the strobe was first seen; drop = {d, i} requests to release.
   task automatic respond(input string nm, input logic [127:0] line, input int lat,
                          input bit to_d, input bit [1:0] drop);
      pmem_rdata = line;
      repeat (lat - 1) tick();
      pmem_resp = 1'b1;
      #1;
      chk({nm, "_iresp"}, 128'(i_pmem_resp), 128'(!to_d));
      chk({nm, "_dresp"}, 128'(d_pmem_resp), 128'(to_d));
      chk({nm, "_rdata"}, to_d ? d_pmem_rdata : i_pmem_rdata, line);
      tick();
      pmem_resp = 1'b0;
      if (drop[0]) i_pmem_read = 1'b0;
      if (drop[1]) begin
         d_pmem_read  = 1'b0;
         d_pmem_write = 1'b0;
      end
      #1;
      chk({nm, "_dead_strobe"}, 128'(pmem_read | pmem_write), 128'(0));
      chk({nm, "_resp_pulse"}, 128'(i_pmem_resp | d_pmem_resp), 128'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [127:0] line_a5;
   logic [127:0] wline;
   bit           exp_grant_d [6];

   initial begin
      rst            = 1'b1;
      i_pmem_read    = 1'b0;
      i_pmem_address = '0;
      d_pmem_read    = 1'b0;
      d_pmem_write   = 1'b0;
      d_pmem_address = '0;
      d_pmem_wdata   = '0;
      pmem_rdata     = '0;
      pmem_resp      = 1'b0;
      checks         = 0;
      failures       = 0;
      line_a5        = {16{8'hA5}};
      wline          = 128'h0123456789ABCDEF0123456789ABCDEF;
      exp_grant_d    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      do_reset();
      chk("reset_read",  128'(pmem_read),    128'(0));
      chk("reset_write", 128'(pmem_write),   128'(0));
      chk("reset_addr",  128'(pmem_address), 128'(0));
      chk("reset_wdata", pmem_wdata,         128'(0));

      // Lone I read
      i_pmem_read    = 1'b1;
      i_pmem_address = 16'h1230;
      tick();
      chk("lone_i_read",  128'(pmem_read),    128'(1));
      chk("lone_i_write", 128'(pmem_write),   128'(0));
      chk("lone_i_addr",  128'(pmem_address), 128'(16'h1230));
      respond("lone_i", line_a5, 3, 1'b0, 2'b01);

      // Lone D write
      d_pmem_write   = 1'b1;
      d_pmem_address = 16'h4560;
      d_pmem_wdata   = wline;
      tick();
      chk("lone_d_write", 128'(pmem_write),   128'(1));
      chk("lone_d_read",  128'(pmem_read),    128'(0));
      chk("lone_d_addr",  128'(pmem_address), 128'(16'h4560));
      chk("lone_d_wdata", pmem_wdata,         128'h0123456789ABCDEF0123456789ABCDEF);
      respond("lone_d", 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2, 1'b1, 2'b10);

      // Simultaneous requests after reset: I first, then D after the dead cycle
      do_reset();
      chk("reset2_addr", 128'(pmem_address), 128'(0));
      i_pmem_read    = 1'b1;
      i_pmem_address = 16'h1111;
      d_pmem_read    = 1'b1;
      d_pmem_address = 16'h2222;
      tick();
      chk("tie_first_addr", 128'(pmem_address), 128'(16'h1111));
      respond("tie_i", 128'hCAFE, 2, 1'b0, 2'b01);
      tick();
      chk("tie_second_addr", 128'(pmem_address), 128'(16'h2222));
      chk("tie_second_read", 128'(pmem_read),    128'(1));
      respond("tie_d", 128'hBEEF, 2, 1'b1, 2'b10);

      // Continuous contention: both hold requests across six transactions
      i_pmem_read    = 1'b1;
      i_pmem_address = 16'h3AAA;
      d_pmem_write   = 1'b1;
      d_pmem_address = 16'h4BBB;
      d_pmem_wdata   = wline;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("cont_strobe_%0d", k), 128'(pmem_read | pmem_write), 128'(1));
         chk($sformatf("cont_grant_%0d", k), 128'(pmem_address == 16'h4BBB), 128'(exp_grant_d[k]));
         respond($sformatf("cont_%0d", k), 128'(k + 100), 2, exp_grant_d[k], 2'b00);
      end
      i_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
      tick();
      chk("cont_quiet", 128'(pmem_read | pmem_write), 128'(0));

      // Request changes mid-transaction are ignored
      d_pmem_read    = 1'b1;
      d_pmem_address = 16'h5550;
      tick();
      chk("hold_addr0", 128'(pmem_address), 128'(16'h5550));
      d_pmem_address = 16'hFFF0;
      d_pmem_wdata   = 128'hDEAD;
      tick();
      chk("hold_addr1", 128'(pmem_address), 128'(16'h5550));
      chk("hold_wdata", pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
      respond("hold", 128'h5A5A, 3, 1'b1, 2'b10);

      // Reset two cycles into SERVE_I, then a late memory response
      i_pmem_read    = 1'b1;
      i_pmem_address = 16'h7770;
      tick();
      chk("rst_mid_strobe", 128'(pmem_read), 128'(1));
      tick();
      tick();
      rst         = 1'b1;
      i_pmem_read = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_mid_read",  128'(pmem_read),  128'(0));
      chk("rst_mid_write", 128'(pmem_write), 128'(0));
      pmem_resp  = 1'b1;
      pmem_rdata = 128'h77;
      #1;
      chk("late_resp_i", 128'(i_pmem_resp), 128'(0));
      chk("late_resp_d", 128'(d_pmem_resp), 128'(0));
      tick();
      pmem_resp = 1'b0;
      i_pmem_read    = 1'b1;
      i_pmem_address = 16'h7777;
      d_pmem_read    = 1'b1;
      d_pmem_address = 16'h8888;
      tick();
      chk("rst_tie_addr", 128'(pmem_address), 128'(16'h7777));
      respond("rst_tie", 128'h99, 2, 1'b0, 2'b11);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the instruction cache and the data cache. It grants one cache at a time and latches the granted request's address and write line. It forwards the full 128-bit line transfer to memory and returns the response only to the granted cache. It sits between the two L1 cache controllers and physical memory; the word-select logic inside each cache sees only the line returned through this block.

## Interface
Parameters:
- none; widths come from the shared package (lc3b_word = 16 bits, lc3b_line = 128 bits).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line-read request; held until i_pmem_resp
- i_pmem_address  in  lc3b_word  I-cache line address
- i_pmem_rdata  out  lc3b_line  line returned to I-cache
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache
- d_pmem_read  in  1  D-cache line-read request; held until d_pmem_resp
- d_pmem_write  in  1  D-cache line-write request; held until d_pmem_resp
- d_pmem_address  in  lc3b_word  D-cache line address
- d_pmem_wdata  in  lc3b_line  D-cache write line
- d_pmem_rdata  out  lc3b_line  line returned to D-cache
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  read strobe to physical memory
- pmem_write  out  1  write strobe to physical memory
- pmem_address  out  lc3b_word  latched address to memory
- pmem_wdata  out  lc3b_line  latched write line to memory
- pmem_rdata  in  lc3b_line  line from memory
- pmem_resp  in  1  memory completion; valid for one cycle

## Operation
**States**
- IDLE: no memory strobes asserted; arbitrate.
- SERVE_I: forward the latched I-cache read.
- SERVE_D: forward the latched D-cache read or write.

**IDLE arbitration**, evaluated every cycle:
- Only I requests: go to SERVE_I.
- Only D requests (read or write): go to SERVE_D.
- Both request: grant the requester not served last. The last_grant register holds 0 = I, 1 = D and updates on every grant.
- Neither requests: stay in IDLE.

**Grant latch**
- On the grant edge, capture the granted address into pmem_address.
- For D, also capture d_pmem_wdata into pmem_wdata and latch the op: write if d_pmem_write=1, else read.
- d_pmem_read and d_pmem_write both high is illegal; the block treats it as a write.

**Serving**
- SERVE_I drives pmem_read=1.
- SERVE_D drives pmem_read or pmem_write from the latched op.
- Strobes and latched fields stay stable until pmem_resp.

**Completion**
- In SERVE_x with pmem_resp=1, x_pmem_resp=1 combinationally in the same cycle.
- Next state is IDLE.
- The non-granted requester's resp stays 0.

**Data paths**
- i_pmem_rdata and d_pmem_rdata both equal pmem_rdata at all times. Only the resp pulses are gated.

## Timing
- Reset values:
  - state=IDLE, last_grant=1, so I wins the first tie.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Both resp outputs are 0.
- Request-to-strobe latency: a request seen in IDLE at cycle N gives a memory strobe in cycle N+1.
- Response latency: x_pmem_resp is asserted in the same cycle as pmem_resp (zero added latency).
- Dead cycle: one mandatory IDLE cycle follows every completion. This lets the served cache deassert its request before the next arbitration. Minimum back-to-back spacing is resp → IDLE → SERVE.
- Fairness: under continuous requests from both caches, grants alternate I, D, I, D; neither waits more than one transaction.
- Request changes after the grant edge are ignored until the next IDLE.
- pmem_resp in IDLE is ignored; no resp is forwarded.
- rst mid-transaction: the next state is IDLE and strobes drop the following cycle. The outstanding memory transaction is abandoned and last_grant returns to 1.
- A request arriving in the same cycle as pmem_resp for the other cache is arbitrated in the following IDLE cycle.

## Structure
- Shared package: lc3b_word and lc3b_line are already there. Add lc3b_arb_state (enum IDLE / SERVE_I / SERVE_D) and lc3b_arb_sel (1 bit, 0 = I, 1 = D).
- One sub-module, cache_arbiter_control, holds the state machine and last_grant. It outputs the grant-load enable, selected requester, and strobe/resp controls.
- The top level holds the address, wdata and op registers and the request muxes.

## Test plan
- **Lone I read:** i_pmem_read, addr 16'h1230; memory resp after 3 cycles with line 128'hA5...A5. Expect pmem_read high from cycle 1, pmem_address=16'h1230, i_pmem_resp for one cycle carrying that line, and d_pmem_resp=0 throughout.
- **Lone D write:** d_pmem_write, addr 16'h4560, wdata 128'h0123...CDEF. Expect pmem_write=1, pmem_read=0, pmem_wdata latched exactly, and a d_pmem_resp pulse.
- **Simultaneous requests after reset:** I served first. After the dead cycle D is served; the I address never appears during SERVE_D.
- **Continuous contention over 6 transactions:** grant order I, D, I, D, I, D. Exactly one IDLE cycle between each completion and the next strobe.
- **Request changes mid-transaction:** d_pmem_address changes during SERVE_D. Expect pmem_address to hold the value latched at grant.
- **rst mid-transaction:** rst asserted two cycles into SERVE_I, then a late pmem_resp arrives. Expect strobes low the next cycle, no i_pmem_resp, and the next tie granted to I.
